// File: rtl/instruction_fetch_queued_pkg.sv
// instruction_fetch_queued_pkg: shared widths, queue entry layout and PC decode helper
package instruction_fetch_queued_pkg;

    localparam int SIZE            = 32;
    localparam int MAX_INSTRUCTION = 64;
    localparam int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION);

    localparam logic [SIZE-1:0] NOP = '0;

    typedef struct packed {
        logic [SIZE-1:0] pc;
        logic [SIZE-1:0] instruction;
        logic            fault;
    } entry_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] index;
        logic                  fault;
    } lookup_t;

    function automatic lookup_t pc_lookup(input logic [SIZE-1:0] pc, input logic byte_addr);
        logic [SIZE-1:0] w;
        lookup_t r;
        w = byte_addr ? pc >> 2 : pc;
        r.index = w[ADDR_WIDTH-1:0];
        r.fault = (w >> ADDR_WIDTH) != '0
               || 32'(w[ADDR_WIDTH-1:0]) >= 32'(MAX_INSTRUCTION)
               || (byte_addr && pc[1:0] != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/instruction_fetch_queued_fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; push and pop may coincide when full
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    assign o_data = store[rd_ptr];

    // pointer and occupancy bookkeeping; flush drops everything including a same-cycle pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(i_push);
            rd_ptr  <= rd_ptr + PW'(i_pop);
            o_level <= o_level + (PW+1)'(i_push) - (PW+1)'(i_pop);
        end
    end

    // entry storage needs no reset since the level gates visibility
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush)
            store[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instruction_fetch_queued.sv
// instruction_fetch_queued: loadable instruction memory feeding a PC-tagged fetch queue
module instruction_fetch_queued
    import instruction_fetch_queued_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter bit BYTE_ADDR   = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_load_mode,
    input  logic                           i_load_valid,
    output logic                           o_load_ready,
    input  logic [SIZE-1:0]                i_load_data,
    input  logic                           i_load_clear,
    output logic [ADDR_WIDTH:0]            o_load_count,
    input  logic                           i_redirect,
    input  logic [SIZE-1:0]                i_redirect_pc,
    output logic                           o_inst_valid,
    input  logic                           i_inst_ready,
    output logic [SIZE-1:0]                o_instruction,
    output logic [SIZE-1:0]                o_pc,
    output logic                           o_fault,
    output logic [$clog2(QUEUE_DEPTH):0]   o_queue_level
);

    localparam int LW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [SIZE-1:0] STEP = BYTE_ADDR ? SIZE'(4) : SIZE'(1);

    logic [SIZE-1:0] mem [MAX_INSTRUCTION];
    logic [SIZE-1:0] f_pc;
    logic            load_mode_q;
    lookup_t         look;
    entry_t          tail, head;
    logic            mode_edge, redirect, flush, pop, push;

    assign look      = pc_lookup(f_pc, BYTE_ADDR);
    assign tail      = '{pc: f_pc, instruction: look.fault ? NOP : mem[look.index], fault: look.fault};
    assign mode_edge = i_load_mode != load_mode_q;
    assign redirect  = i_redirect && !i_load_mode;
    assign flush     = redirect || mode_edge;
    assign pop       = o_inst_valid && i_inst_ready;
    assign push      = !i_load_mode && !flush && (o_queue_level < LW'(QUEUE_DEPTH) || pop);

    assign o_load_ready  = !i_rst && i_load_mode && o_load_count < (ADDR_WIDTH+1)'(MAX_INSTRUCTION);
    assign o_inst_valid  = o_queue_level != '0;
    assign o_instruction = o_inst_valid ? head.instruction : NOP;
    assign o_pc          = o_inst_valid ? head.pc : '0;
    assign o_fault       = o_inst_valid && head.fault;

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH($bits(entry_t))) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (flush),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (tail),
        .o_data  (head),
        .o_level (o_queue_level)
    );

    // fetch PC steering, load-mode edge tracking and loader writes into memory
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_INSTRUCTION; i++)
                mem[i] <= '0;
            f_pc         <= '0;
            load_mode_q  <= 1'b0;
            o_load_count <= '0;
        end else begin
            load_mode_q <= i_load_mode;
            if (!i_load_mode && load_mode_q)
                f_pc <= '0;
            else if (redirect)
                f_pc <= i_redirect_pc;
            else if (push)
                f_pc <= f_pc + STEP;
            if (i_load_clear)
                o_load_count <= '0;
            else if (i_load_valid && o_load_ready) begin
                mem[o_load_count[ADDR_WIDTH-1:0]] <= i_load_data;
                o_load_count <= o_load_count + 1'b1;
            end
        end
    end

endmodule
